// File: rtl/idelay_scan_pkg.sv
// Shared types and helpers for the multi-lane IDELAY scanner.
// The optional bitmap readback is enabled by the IDELAY_SCAN_BITMAP_EN macro in idelay_scan_multi.
package idelay_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DECIDE = 3'd4,
        S_APPLY  = 3'd5
    } scan_state_t;

    localparam logic [1:0] ST_FAIL     = 2'd0;
    localparam logic [1:0] ST_MARGINAL = 2'd1;
    localparam logic [1:0] ST_GOOD     = 2'd2;
    localparam logic [1:0] ST_SOFTWARE = 2'd3;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/idelay_run_finder.sv
// Serial longest-run finder: one bitmap bit per enabled cycle, start marks bit 0.
// After the last bit, done pulses with the first longest run of ones (len, run_start).
module idelay_run_finder #(
    parameter int IW = 5
) (
    input  logic          lb_clk,
    input  logic          reset,
    input  logic          bit_en,
    input  logic          start,
    input  logic          bit_in,
    output logic [IW:0]   len,
    output logic [IW-1:0] run_start,
    output logic          done
);

    logic [IW-1:0] idx, cur_start, best_start;
    logic [IW:0]   cur_len, best_len;

    logic [IW-1:0] i_eff, c_start, b_start, n_cur_start, n_best_start;
    logic [IW:0]   c_len, b_len, n_cur_len, n_best_len;

    always_comb begin
        i_eff   = start ? '0 : idx;
        c_len   = start ? '0 : cur_len;
        c_start = start ? '0 : cur_start;
        b_len   = start ? '0 : best_len;
        b_start = start ? '0 : best_start;

        n_cur_len   = '0;
        n_cur_start = c_start;
        if (bit_in) begin
            n_cur_len   = c_len + 1'b1;
            n_cur_start = (c_len == '0) ? i_eff : c_start;
        end

        // Strictly longer only, so an equal later run never displaces the earlier one.
        n_best_len   = b_len;
        n_best_start = b_start;
        if (n_cur_len > b_len) begin
            n_best_len   = n_cur_len;
            n_best_start = n_cur_start;
        end
    end

    always_ff @(posedge lb_clk) begin
        if (reset) begin
            idx        <= '0;
            cur_len    <= '0;
            cur_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
            len        <= '0;
            run_start  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bit_en) begin
                idx        <= i_eff + 1'b1;
                cur_len    <= n_cur_len;
                cur_start  <= n_cur_start;
                best_len   <= n_best_len;
                best_start <= n_best_start;
                if (i_eff == '1) begin
                    done      <= 1'b1;
                    len       <= n_best_len;
                    run_start <= n_best_start;
                end
            end
        end
    end

endmodule

// File: rtl/idelay_scan_multi.sv
// Multi-lane IDELAY tap scanner: sweeps all taps, builds per-lane pass bitmaps, picks run centres.
// Define IDELAY_SCAN_BITMAP_EN to expose the per-lane bitmap on bitmap_val (otherwise it reads 0).
module idelay_scan_multi
    import idelay_scan_pkg::*;
#(
    parameter int             NLANE   = 16,
    parameter int             TAPW    = 5,
    parameter int             DW      = 8,
    parameter logic [DW-1:0]  PATTERN = 8'h0c,
    parameter int             SETTLE  = 15,
    parameter int             NSAMP   = 16,
    parameter int             MINRUN  = 4,
    localparam int            LAW     = clog2w(NLANE)
) (
    input  logic                  lb_clk,
    input  logic                  reset,
    input  logic                  scan_trigger,
    input  logic                  autoset_enable,
    input  logic                  lb_id_write,
    input  logic [LAW-1:0]        lb_addr,
    input  logic [TAPW-1:0]       lb_data,
    input  logic [NLANE*DW-1:0]   lane_data,
    input  logic                  lane_valid,
    output logic                  scan_running,
    output logic                  scan_done,
    output logic [LAW-1:0]        hw_addr,
    output logic [TAPW-1:0]       hw_data,
    output logic                  hw_strobe,
    input  logic [LAW-1:0]        ro_addr,
    output logic [TAPW+1:0]       mirror_val,
    output logic [2**TAPW-1:0]    bitmap_val,
    output logic [2:0]            state_dbg
);

    localparam int NTAP = 2**TAPW;
    localparam logic [LAW-1:0]  LANE_LAST   = LAW'(NLANE - 1);
    localparam logic [TAPW-1:0] TAP_LAST    = '1;
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0]      NSAMP_LAST  = 8'(NSAMP - 1);
    localparam logic [TAPW:0]   MINRUN_L    = (TAPW+1)'(MINRUN);

    scan_state_t state, next_state;

    logic [TAPW-1:0]     tap;
    logic [LAW-1:0]      lane_cnt;
    logic [7:0]          cnt;
    logic [LAW+TAPW-1:0] dec_idx;
    logic [LAW-1:0]      res_lane;
    logic [NTAP-1:0]     bm [NLANE];
    logic [TAPW+1:0]     mirror [NLANE];

    logic            fin_en, fin_start, fin_bit, fin_done;
    logic [TAPW:0]   fin_len;
    logic [TAPW-1:0] fin_run_start;
    logic [TAPW+1:0] dec_word;
    logic [1:0]      apply_status;

    assign scan_running = (state != S_IDLE);
    assign state_dbg    = state;

    // lane_valid is a valid-only qualifier (no ready): a lane_data word is consumed
    // on every cycle lane_valid is high while in SAMPLE and ignored at all other times.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:   if (!lb_id_write && scan_trigger) next_state = S_WRITE;
            S_WRITE:  if (lane_cnt == LANE_LAST) next_state = S_SETTLE;
            S_SETTLE: if (cnt == SETTLE_LAST) next_state = S_SAMPLE;
            S_SAMPLE: if (lane_valid && cnt == NSAMP_LAST)
                          next_state = (tap == TAP_LAST) ? S_DECIDE : S_WRITE;
            S_DECIDE: if (dec_idx == '1) next_state = S_APPLY;
            S_APPLY:  if (lane_cnt == LANE_LAST) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge lb_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // dec_idx walks lane-major, tap-minor, so the tap field hitting zero marks a new lane.
    assign fin_en    = (state == S_DECIDE);
    assign fin_start = (dec_idx[TAPW-1:0] == '0);
    assign fin_bit   = bm[dec_idx[LAW+TAPW-1:TAPW]][dec_idx[TAPW-1:0]];

    idelay_run_finder #(.IW(TAPW)) u_finder (
        .lb_clk    (lb_clk),
        .reset     (reset),
        .bit_en    (fin_en),
        .start     (fin_start),
        .bit_in    (fin_bit),
        .len       (fin_len),
        .run_start (fin_run_start),
        .done      (fin_done)
    );

    always_comb begin
        dec_word = '0;
        if (fin_len != '0) begin
            dec_word[TAPW-1:0]      = fin_run_start + TAPW'((fin_len - 1'b1) >> 1);
            dec_word[TAPW+1:TAPW]   = (fin_len >= MINRUN_L) ? ST_GOOD : ST_MARGINAL;
        end
    end

    assign apply_status = mirror[lane_cnt][TAPW+1:TAPW];

    always_ff @(posedge lb_clk) begin
        if (reset) begin
            tap       <= '0;
            lane_cnt  <= '0;
            cnt       <= '0;
            dec_idx   <= '0;
            res_lane  <= '0;
            hw_strobe <= 1'b0;
            hw_addr   <= '0;
            hw_data   <= '0;
            scan_done <= 1'b0;
            for (int k = 0; k < NLANE; k++) begin
                bm[k]     <= '0;
                mirror[k] <= '0;
            end
        end else begin
            hw_strobe <= 1'b0;
            scan_done <= (state == S_APPLY) && (next_state == S_IDLE);

            if (state != next_state) begin
                lane_cnt <= '0;
                cnt      <= '0;
            end else if (state == S_WRITE || state == S_APPLY) begin
                lane_cnt <= lane_cnt + 1'b1;
            end else if (state == S_SETTLE || (state == S_SAMPLE && lane_valid)) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (lb_id_write) begin
                        hw_strobe       <= 1'b1;
                        hw_addr         <= lb_addr;
                        hw_data         <= lb_data;
                        mirror[lb_addr] <= {ST_SOFTWARE, lb_data};
                    end else if (scan_trigger) begin
                        tap <= '0;
                        for (int k = 0; k < NLANE; k++) bm[k] <= '1;
                    end
                end
                S_WRITE: begin
                    hw_strobe <= 1'b1;
                    hw_addr   <= lane_cnt;
                    hw_data   <= tap;
                end
                S_SAMPLE: begin
                    if (lane_valid) begin
                        for (int k = 0; k < NLANE; k++) begin
                            if (lane_data[k*DW +: DW] != PATTERN) bm[k][tap] <= 1'b0;
                        end
                        if (next_state == S_WRITE) tap <= tap + 1'b1;
                    end
                end
                S_DECIDE: begin
                    dec_idx  <= dec_idx + 1'b1;
                    res_lane <= dec_idx[LAW+TAPW-1:TAPW];
                end
                S_APPLY: begin
                    if (autoset_enable && apply_status != ST_FAIL) begin
                        hw_strobe <= 1'b1;
                        hw_addr   <= lane_cnt;
                        hw_data   <= mirror[lane_cnt][TAPW-1:0];
                    end
                end
                default: ;
            endcase

            // The last lane's result lands during the first APPLY cycle, before APPLY reads it.
            if (fin_done) mirror[res_lane] <= dec_word;
        end
    end

    always_ff @(posedge lb_clk) begin
        if (reset) begin
            mirror_val <= '0;
            bitmap_val <= '0;
        end else begin
            mirror_val <= mirror[ro_addr];
`ifdef IDELAY_SCAN_BITMAP_EN
            bitmap_val <= bm[ro_addr];
`else
            bitmap_val <= '0;
`endif
        end
    end

endmodule
